multicycle_core: RTL and testbench

Multi-cycle MIPS core that replaces the single-cycle datapath. It time-shares one ALU and one unified instruction/data memory port across several clock cycles per instruction, with control from an internal state machine. The memory port uses a req/ready handshake, so wait-state memories stall the core. Supported instructions: R-type add/sub/and/or/slt/jr, lw, sw, beq, addi, j; unknown opcodes are configurable as trap or NOP.

---
 rtl/multicycle_core_if.sv | 20 ++
 rtl/multicycle_core.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_core.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_core_if.sv
// Unified instruction/data memory port of the multi-cycle core.
// The core drives the request side and the memory answers with ready/rdata.
interface multicycle_core_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle MIPS subset core: one shared ALU, one shared memory port with
// req/ready stalls, sequenced by a single state machine.
module multicycle_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_core_if.master mem,
  output logic [31:0]       pc,
  output logic              retire,
  output logic              halted
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPE,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A, FN_JR = 6'h08;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR = 3'b001, ALU_SLT = 3'b111;

  state_t             state;
  logic [31:0]        ir, mdr, a_reg, b_reg, alu_out;
  logic [31:0]        rf [32];
  logic [5:0]         op, funct;
  logic [4:0]         rs, rt, rd;
  logic signed [31:0] sext;
  logic [2:0]         fn_ctl, alu_ctl;
  logic               fn_ok, op_ok;
  logic signed [31:0] alu_x, alu_y;
  logic [31:0]        alu_res, rd_a, rd_b;
  logic               alu_zero;
  logic               rf_we;
  logic [4:0]         rf_waddr;
  logic [31:0]        rf_wdata;
  logic               retire_c;

  function automatic logic [31:0] alu(input logic [2:0] ctl,
                                      input logic signed [31:0] x,
                                      input logic signed [31:0] y);
    case (ctl)
      ALU_ADD: return x + y;
      ALU_SUB: return x - y;
      ALU_AND: return x & y;
      ALU_OR:  return x | y;
      ALU_SLT: return {31'd0, (x < y)};
      default: return '0;
    endcase
  endfunction

  assign op    = ir[31:26];
  assign rs    = ir[25:21];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];
  assign funct = ir[5:0];
  assign sext  = {{16{ir[15]}}, ir[15:0]};
  assign rd_a  = (rs == 5'd0) ? '0 : rf[rs];
  assign rd_b  = (rt == 5'd0) ? '0 : rf[rt];

  always_comb begin
    fn_ok  = 1'b1;
    fn_ctl = ALU_ADD;
    case (funct)
      FN_ADD:  fn_ctl = ALU_ADD;
      FN_SUB:  fn_ctl = ALU_SUB;
      FN_AND:  fn_ctl = ALU_AND;
      FN_OR:   fn_ctl = ALU_OR;
      FN_SLT:  fn_ctl = ALU_SLT;
      default: fn_ok = 1'b0;
    endcase
  end

  assign op_ok = (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
                 (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);

  // The single ALU is steered by state: PC+4, branch target, address/addi, R-op, compare.
  always_comb begin
    alu_ctl = ALU_ADD;
    alu_x   = $signed(a_reg);
    alu_y   = sext;
    case (state)
      S_FETCH:  begin alu_x = $signed(pc); alu_y = 32'sd4; end
      S_DECODE: begin alu_x = $signed(pc); alu_y = sext <<< 2; end
      S_RTYPE:  begin alu_y = $signed(b_reg); alu_ctl = fn_ctl; end
      S_BRANCH: begin alu_y = $signed(b_reg); alu_ctl = ALU_SUB; end
      default:  ;
    endcase
  end

  assign alu_res  = alu(alu_ctl, alu_x, alu_y);
  assign alu_zero = (alu_res == '0);

  always_comb begin
    retire_c = 1'b0;
    case (state)
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire_c = 1'b1;
      S_MEMWR:  retire_c = mem.mem_ready;
      S_RTYPE:  retire_c = (funct == FN_JR) || (!fn_ok && !TRAP_ON_ILLEGAL);
      S_DECODE: retire_c = !op_ok && !TRAP_ON_ILLEGAL;
      default:  retire_c = 1'b0;
    endcase
  end

  // Reset gates every side effect of the cycle it is asserted in.
  assign retire = retire_c && !rst;
  assign halted = (state == S_TRAP);

  assign mem.mem_req   = !rst && ((state == S_FETCH) || (state == S_MEMRD) ||
                                  (state == S_MEMWR));
  assign mem.mem_we    = (state == S_MEMWR);
  assign mem.mem_addr  = (state == S_FETCH) ? pc : alu_out;
  assign mem.mem_wdata = b_reg;

  assign rf_waddr = (state == S_ALUWB) ? rd : rt;
  assign rf_wdata = (state == S_MEMWB) ? mdr : alu_out;
  assign rf_we    = !rst && (rf_waddr != 5'd0) &&
                    ((state == S_MEMWB) || (state == S_ALUWB) || (state == S_ADDIWB));

  always_ff @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem.mem_ready) begin
          ir    <= mem.mem_rdata;
          pc    <= alu_res;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a_reg   <= rd_a;
          b_reg   <= rd_b;
          alu_out <= alu_res;
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_RTYPE;
            OP_BEQ:       state <= S_BRANCH;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JUMP;
            default:      state <= TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
          endcase
        end
        S_MEMADR: begin
          alu_out <= alu_res;
          state   <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: if (mem.mem_ready) begin
          mdr   <= mem.mem_rdata;
          state <= S_MEMWB;
        end
        S_MEMWR: if (mem.mem_ready) state <= S_FETCH;
        S_RTYPE: begin
          if (funct == FN_JR) begin
            pc    <= a_reg;
            state <= S_FETCH;
          end else if (fn_ok) begin
            alu_out <= alu_res;
            state   <= S_ALUWB;
          end else begin
            state <= TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
          end
        end
        S_BRANCH: begin
          if (alu_zero) pc <= alu_out;
          state <= S_FETCH;
        end
        S_ADDIEX: begin
          alu_out <= alu_res;
          state   <= S_ADDIWB;
        end
        S_JUMP: begin
          pc    <= {pc[31:28], ir[25:0], 2'b00};
          state <= S_FETCH;
        end
        S_MEMWB, S_ALUWB, S_ADDIWB: state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: an ISA-level model predicts every bus cycle,
// retire pulse and PC of the trapping core; directed vectors pin the model.
module tb_multicycle_core;
  localparam bit TRAP_P = 1'b1;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [31:0] pc, pc2;
  logic        retire, retire2, halted, halted2;

  always #5 clk = ~clk;

  multicycle_core_if bus ();
  multicycle_core_if bus2 ();

  multicycle_core #(.RESET_PC(32'h0000_0100), .TRAP_ON_ILLEGAL(TRAP_P)) dut (
    .clk(clk), .rst(rst), .mem(bus), .pc(pc), .retire(retire), .halted(halted));

  multicycle_core #(.RESET_PC(32'h0000_0000), .TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst(rst2), .mem(bus2), .pc(pc2), .retire(retire2), .halted(halted2));

  logic [31:0] mem  [256];
  logic [31:0] mem2 [64];
  logic [31:0] slow_addr;
  int          slow_n;
  int          wcnt;
  int          errors = 0;
  int          checks = 0;

  assign bus.mem_ready  = bus.mem_req && ((bus.mem_addr != slow_addr) || (wcnt >= slow_n));
  assign bus.mem_rdata  = mem[bus.mem_addr[9:2]];
  assign bus2.mem_ready = bus2.mem_req;
  assign bus2.mem_rdata = mem2[bus2.mem_addr[7:2]];

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] t);
    return {6'h02, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Memory side effects: writes land at the edge that completes the access.
  initial begin : responder
    logic        acc, we, req, acc2;
    logic [31:0] a, d, a2, d2;
    wcnt = 0;
    forever begin
      @(negedge clk);
      acc  = bus.mem_req && bus.mem_ready;
      we   = bus.mem_we;
      req  = bus.mem_req;
      a    = bus.mem_addr;
      d    = bus.mem_wdata;
      acc2 = bus2.mem_req && bus2.mem_we;
      a2   = bus2.mem_addr;
      d2   = bus2.mem_wdata;
      @(posedge clk);
      #1;
      if (acc && we) mem[a[9:2]] = d;
      if (acc2) mem2[a2[7:2]] = d2;
      wcnt = (acc || !req) ? 0 : wcnt + 1;
    end
  end

  // ISA-level reference: registers, next PC, expected bus access and latency per instruction.
  logic [31:0] mreg [32];
  logic [31:0] mpc, pc4, nxt_pc, exp_addr, exp_wdata, wr_val;
  logic [4:0]  wr_idx;
  logic        pend, halted_exp, prev_stall, is_lw, m_we, illegal, exp_ret;
  int          n, lat, req_n, ill_n;

  task automatic model_decode(input logic [31:0] ins, input logic [31:0] fa);
    logic [31:0] sx, ra, rb;
    sx = {{16{ins[15]}}, ins[15:0]};
    ra = mreg[ins[25:21]];
    rb = mreg[ins[20:16]];
    pc4 = fa + 32'd4;
    nxt_pc = pc4;
    wr_idx = 5'd0; wr_val = '0; lat = 0; req_n = 0; ill_n = 0;
    illegal = 1'b0; is_lw = 1'b0; m_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    case (ins[31:26])
      6'h23: begin lat = 5; req_n = 4; is_lw = 1'b1; exp_addr = ra + sx; wr_idx = ins[20:16]; end
      6'h2B: begin lat = 4; req_n = 4; m_we = 1'b1; exp_addr = ra + sx; exp_wdata = rb; end
      6'h08: begin lat = 4; wr_idx = ins[20:16]; wr_val = ra + sx; end
      6'h04: begin lat = 3; if (ra == rb) nxt_pc = pc4 + (sx << 2); end
      6'h02: begin lat = 3; nxt_pc = {pc4[31:28], ins[25:0], 2'b00}; end
      6'h00: begin
        lat = 4;
        wr_idx = ins[15:11];
        case (ins[5:0])
          6'h20: wr_val = ra + rb;
          6'h22: wr_val = ra - rb;
          6'h24: wr_val = ra & rb;
          6'h25: wr_val = ra | rb;
          6'h2A: wr_val = ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0;
          6'h08: begin lat = 3; wr_idx = 5'd0; nxt_pc = ra; end
          default: begin illegal = 1'b1; ill_n = 3; wr_idx = 5'd0; end
        endcase
      end
      default: begin illegal = 1'b1; ill_n = 2; end
    endcase
    if (illegal) lat = TRAP_P ? 0 : ill_n;
  endtask

  initial begin : compare
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    mpc = 32'h100; pend = 1'b0; halted_exp = 1'b0; prev_stall = 1'b0; n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk1("rst_req", bus.mem_req, 1'b0);
        chk1("rst_retire", retire, 1'b0);
        mpc = 32'h100; pend = 1'b0; halted_exp = 1'b0; prev_stall = 1'b0;
      end else if (halted_exp) begin
        chk1("trap_halted", halted, 1'b1);
        chk1("trap_req", bus.mem_req, 1'b0);
        chk1("trap_retire", retire, 1'b0);
      end else begin
        chk1("halted", halted, 1'b0);
        if (!pend) begin
          chk("fetch_pc", pc, mpc);
          chk1("fetch_req", bus.mem_req, 1'b1);
          chk1("fetch_we", bus.mem_we, 1'b0);
          chk("fetch_addr", bus.mem_addr, mpc);
          chk1("fetch_retire", retire, 1'b0);
          if (bus.mem_req && bus.mem_ready) begin
            model_decode(bus.mem_rdata, bus.mem_addr);
            pend = 1'b1;
            n = 1;
          end
        end else begin
          if (!prev_stall) n++;
          chk("exec_pc", pc, pc4);
          chk1("data_req", bus.mem_req, n == req_n);
          if (bus.mem_req && n == req_n) begin
            chk1("data_we", bus.mem_we, m_we);
            chk("data_addr", bus.mem_addr, exp_addr);
            if (m_we) chk("data_wdata", bus.mem_wdata, exp_wdata);
          end
          exp_ret = (n == lat) && !(bus.mem_req && !bus.mem_ready);
          chk1("retire", retire, exp_ret);
          if (is_lw && bus.mem_req && bus.mem_ready) wr_val = bus.mem_rdata;
          if (exp_ret) begin
            if (wr_idx != 5'd0) mreg[wr_idx] = wr_val;
            mpc = nxt_pc;
            pend = 1'b0;
          end else if (illegal && TRAP_P && n == ill_n) begin
            halted_exp = 1'b1;
            pend = 1'b0;
            mpc = pc4;
          end
        end
        prev_stall = bus.mem_req && !bus.mem_ready;
      end
    end
  end

  task automatic wait_fetch(input logic [31:0] a, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(bus.mem_req && bus.mem_ready && !bus.mem_we && bus.mem_addr == a) && cyc < budget);
    if (!(bus.mem_req && bus.mem_ready && !bus.mem_we && bus.mem_addr == a)) begin
      checks++; errors++;
      $display("FAIL wait_fetch_%h: timeout after %0d cycles", a, cyc);
    end
  endtask

  task automatic wait_halt(input int budget);
    int cyc;
    cyc = 0;
    while (!halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk1("reach_halt", halted, 1'b1);
  endtask

  initial begin : main
    int cyc;
    logic [31:0] ill;
    ill = 32'hFC00_0000;
    rst = 1'b1; rst2 = 1'b1;
    slow_addr = 32'h8; slow_n = 3;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 64; i++) mem2[i] = '0;
    mem[32'h100 >> 2] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    mem[32'h104 >> 2] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    mem[32'h108 >> 2] = enc_r(5'd2, 5'd1, 5'd3, 6'h2A);
    mem[32'h10C >> 2] = enc_r(5'd1, 5'd1, 5'd4, 6'h22);
    mem[32'h110 >> 2] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0008);
    mem[32'h114 >> 2] = enc_i(6'h23, 5'd0, 5'd5, 16'h0008);
    mem[32'h118 >> 2] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    mem[32'h11C >> 2] = enc_r(5'd1, 5'd2, 5'd6, 6'h20);
    mem[32'h120 >> 2] = enc_r(5'd1, 5'd2, 5'd7, 6'h24);
    mem[32'h124 >> 2] = enc_r(5'd1, 5'd2, 5'd8, 6'h25);
    mem[32'h128 >> 2] = enc_j(26'h4);
    mem[32'h010 >> 2] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    mem[32'h014 >> 2] = ill;
    mem[32'h018 >> 2] = ill;
    mem[32'h01C >> 2] = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
    mem[32'h020 >> 2] = enc_i(6'h08, 5'd0, 5'd9, 16'h0200);
    mem[32'h024 >> 2] = enc_r(5'd9, 5'd0, 5'd0, 6'h08);
    mem[32'h200 >> 2] = enc_i(6'h2B, 5'd0, 5'd2, 16'h0300);
    mem[32'h204 >> 2] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0304);
    mem[32'h208 >> 2] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0308);
    mem[32'h20C >> 2] = enc_i(6'h2B, 5'd0, 5'd5, 16'h030C);
    mem[32'h210 >> 2] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0310);
    mem[32'h214 >> 2] = enc_i(6'h2B, 5'd0, 5'd6, 16'h0314);
    mem[32'h218 >> 2] = enc_i(6'h2B, 5'd0, 5'd7, 16'h0318);
    mem[32'h21C >> 2] = enc_i(6'h2B, 5'd0, 5'd8, 16'h031C);
    mem[32'h220 >> 2] = enc_j(26'h60);
    mem[32'h180 >> 2] = ill;
    mem2[0] = ill;
    mem2[1] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
    mem2[2] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0040);
    mem2[3] = enc_j(26'h3);

    // Reset and first fetch
    @(negedge clk);
    @(negedge clk);
    chk("reset_pc", pc, 32'h100);
    chk1("reset_halted", halted, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk1("first_req", bus.mem_req, 1'b1);
    chk("first_addr", bus.mem_addr, 32'h100);
    wait_fetch(32'h104, 20, cyc);
    chk("addi_fetch_gap", cyc, 4);

    // Store with three wait states
    wait_fetch(32'h110, 40, cyc);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk1("sw_req", bus.mem_req, 1'b1);
      chk1("sw_we", bus.mem_we, 1'b1);
      chk("sw_addr", bus.mem_addr, 32'h8);
      chk("sw_wdata", bus.mem_wdata, 32'h5);
      chk1("sw_retire", retire, k == 3);
    end

    wait_halt(600);
    chk("mem_slt_src", mem[32'h300 >> 2], 32'hFFFF_FFFD);
    chk("mem_slt", mem[32'h304 >> 2], 32'h1);
    chk("mem_sub", mem[32'h308 >> 2], 32'h0);
    chk("mem_lw", mem[32'h30C >> 2], 32'h5);
    chk("mem_r0", mem[32'h310 >> 2], 32'h0);
    chk("mem_add", mem[32'h314 >> 2], 32'h2);
    chk("mem_and", mem[32'h318 >> 2], 32'h5);
    chk("mem_or", mem[32'h31C >> 2], 32'hFFFF_FFFD);
    chk("mem_sw_slow", mem[2], 32'h5);
    chk("trap_pc", pc, 32'h184);
    repeat (5) @(negedge clk);
    chk1("trap_still_halted", halted, 1'b1);

    // Recover from TRAP, then abandon a stalled load with reset
    @(posedge clk); #1;
    rst = 1'b1;
    mem[2] = 32'h77;
    mem[32'h100 >> 2] = enc_i(6'h23, 5'd0, 5'd1, 16'h0008);
    slow_n = 6;
    @(negedge clk);
    chk1("trap_rst_req", bus.mem_req, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(bus.mem_req && !bus.mem_we && bus.mem_addr == 32'h8) && cyc < 20);
    chk1("lw_wait_seen", bus.mem_req && !bus.mem_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    mem[32'h100 >> 2] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0320);
    mem[32'h104 >> 2] = ill;
    @(negedge clk);
    chk1("midop_rst_req", bus.mem_req, 1'b0);
    chk1("midop_rst_retire", retire, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    wait_halt(60);
    chk("no_rf_write", mem[32'h320 >> 2], 32'h5);
    chk("trap2_pc", pc, 32'h108);

    // Illegal opcode retired as NOP
    @(posedge clk); #1 rst2 = 1'b0;
    @(negedge clk);
    chk1("nop_fetch_req", bus2.mem_req, 1'b1);
    chk("nop_fetch_addr", bus2.mem_addr, 32'h0);
    chk1("nop_fetch_retire", retire2, 1'b0);
    @(negedge clk);
    chk1("nop_retire", retire2, 1'b1);
    chk1("nop_decode_req", bus2.mem_req, 1'b0);
    @(negedge clk);
    chk1("nop_next_req", bus2.mem_req, 1'b1);
    chk("nop_next_addr", bus2.mem_addr, 32'h4);
    chk1("nop_halted", halted2, 1'b0);
    repeat (20) @(negedge clk);
    chk("nop_then_addi_sw", mem2[16], 32'h9);
    chk1("nop_never_halts", halted2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
